// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cache_pkg                                              |
// | Description : Shared types and helpers for the 4-way cache           |
// |               controller (FSM states, way index, one-hot helpers).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cache_pkg;

    localparam int NUM_WAYS = 4;

    typedef logic [1:0] way_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MEM_RD = 3'd2,
        FILL   = 3'd3,
        MEM_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    // One-hot write-enable vector for a way index.
    function automatic logic [NUM_WAYS-1:0] onehot(input way_t w);
        onehot    = '0;
        onehot[w] = 1'b1;
    endfunction

    // Index of the lowest set bit; way 0 when none is set.
    function automatic way_t lowest_way(input logic [NUM_WAYS-1:0] v);
        lowest_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_way = way_t'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cache_tag_store                                        |
// | Description : Tag and valid arrays for every set/way, 4-way tag      |
// |               compare, hit-way and victim selection.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int bitsDirect = 10,
    parameter int TAG_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [bitsDirect-1:0] idx,
    input  logic [TAG_W-1:0]      req_tag,
    input  way_t                  rr_ptr,
    input  logic                  wr_en,
    input  way_t                  wr_way,
    output logic                  hit,
    output way_t                  hit_way,
    output way_t                  victim,
    output logic                  evict
);

    localparam int SETS = 2 ** bitsDirect;

    logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [NUM_WAYS-1:0] hit_vec;
    logic [NUM_WAYS-1:0] set_valid;

    assign set_valid = valid_q[idx];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way_cmp
        assign hit_vec[w] = set_valid[w] && (tag_q[idx][w] == req_tag);
    end

    // Hit and victim selection; duplicate hits resolve to the lowest way.
    always_comb begin
        hit     = |hit_vec;
        hit_way = lowest_way(hit_vec);
        evict   = &set_valid;
        victim  = evict ? rr_ptr : lowest_way(~set_valid);
    end

    // Valid bits: cleared asynchronously, set when a line is filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (wr_en) begin
            valid_q[idx][wr_way] <= 1'b1;
        end
    end

    // Tags need no reset: they are only trusted when the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) tag_q[idx][wr_way] <= req_tag;
    end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cache_ctrl                                             |
// | Description : Controller for a 4-way data array. Single-word CPU     |
// |               reads/writes, miss fill over a req/ack memory port,    |
// |               write-through / no-write-allocate, hit/miss counters.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int bitsDirect  = 10,
    parameter int sizeBitLine = 32,
    parameter int ADDR_W      = 20,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   gen_reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [sizeBitLine-1:0] cpu_wdata,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic [sizeBitLine-1:0] cpu_rdata,
    output logic                   cache_re,
    output logic [NUM_WAYS-1:0]    cache_we,
    output logic [bitsDirect-1:0]  cache_addr,
    output logic [sizeBitLine-1:0] cache_wdata,
    input  logic [sizeBitLine-1:0] cache_rdata1,
    input  logic [sizeBitLine-1:0] cache_rdata2,
    input  logic [sizeBitLine-1:0] cache_rdata3,
    input  logic [sizeBitLine-1:0] cache_rdata4,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [sizeBitLine-1:0] mem_wdata,
    input  logic                   mem_ack,
    input  logic [sizeBitLine-1:0] mem_rdata,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - bitsDirect;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
    logic                   req_we_q, req_we_d;
    logic [sizeBitLine-1:0] req_wdata_q, req_wdata_d;
    logic [sizeBitLine-1:0] line_q, line_d;
    logic [sizeBitLine-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
    way_t                   rr_ptr_q, rr_ptr_d;

    logic                   hit;
    logic                   evict;
    way_t                   hit_way;
    way_t                   victim;
    logic [sizeBitLine-1:0] hit_data;
    logic [bitsDirect-1:0]  req_idx;

    assign req_idx   = req_addr_q[bitsDirect-1:0];
    assign cpu_rdata = rdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    cache_tag_store #(
        .bitsDirect (bitsDirect),
        .TAG_W      (TAG_W)
    ) u_tag_store (
        .clk     (clk),
        .rst_n   (gen_reset),
        .idx     (req_idx),
        .req_tag (req_addr_q[ADDR_W-1:bitsDirect]),
        .rr_ptr  (rr_ptr_q),
        .wr_en   (state_q == FILL),
        .wr_way  (victim),
        .hit     (hit),
        .hit_way (hit_way),
        .victim  (victim),
        .evict   (evict)
    );

    // Select the read word of the hitting way.
    always_comb begin
        case (hit_way)
            2'd0:    hit_data = cache_rdata1;
            2'd1:    hit_data = cache_rdata2;
            2'd2:    hit_data = cache_rdata3;
            default: hit_data = cache_rdata4;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge gen_reset) begin
        if (!gen_reset) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            line_q      <= '0;
            rdata_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            line_q      <= line_d;
            rdata_q     <= rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req) state_d = LOOKUP;
            LOOKUP:  state_d = req_we_q ? MEM_WR : (hit ? RESP : MEM_RD);
            MEM_RD:  if (mem_ack) state_d = FILL;
            FILL:    state_d = RESP;
            MEM_WR:  if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read-data latching, counters and round-robin pointer.
    always_comb begin
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        line_d      = line_q;
        rdata_d     = rdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    req_addr_d  = cpu_addr;
                    req_we_d    = cpu_we;
                    req_wdata_d = cpu_wdata;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    if (!req_we_q) rdata_d = hit_data;
                end else begin
                    if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
            end
            MEM_RD: begin
                if (mem_ack) line_d = mem_rdata;
            end
            FILL: begin
                rdata_d = line_q;
                if (evict) rr_ptr_d = rr_ptr_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Output decode; everything idles at zero outside its owning state.
    always_comb begin
        cpu_busy    = (state_q != IDLE);
        cpu_done    = 1'b0;
        cache_re    = 1'b0;
        cache_we    = '0;
        cache_addr  = '0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req && gen_reset) begin
                    cache_re   = 1'b1;
                    cache_addr = cpu_addr[bitsDirect-1:0];
                end
            end
            LOOKUP: begin
                cache_addr = req_idx;
                if (req_we_q && hit) begin
                    cache_we    = onehot(hit_way);
                    cache_wdata = req_wdata_q;
                end
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
            end
            FILL: begin
                cache_we    = onehot(victim);
                cache_addr  = req_idx;
                cache_wdata = line_q;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = req_addr_q;
                mem_wdata = req_wdata_q;
            end
            RESP: cpu_done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
